swap_reg_arbiter: RTL and testbench

SWAP_REG_ARBITER -- requirements
Module: swap_reg_arbiter

---
 rtl/swap_reg_arbiter.sv | 111 +++++++++++
 tb/tb_swap_reg_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/swap_reg_arbiter.sv
// Two-requester round-robin arbiter loading a pair of shift registers A/B, with an optional A<->B exchange.
// The exchange operation exists only when SWAP_REG_ARBITER_SWAP_EN is defined; otherwise swap_req is ignored.
module swap_reg_arbiter (
  input  logic       clock,
  input  logic       reset,
  input  logic       req1,
  input  logic [3:0] data1,
  input  logic       req2,
  input  logic [3:0] data2,
  input  logic       swap_req,
  output logic       gnt1,
  output logic       gnt2,
  output logic       busy,
  output logic [3:0] reg_a,
  output logic [3:0] reg_b,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT1 = 2'd1,
    GRANT2 = 2'd2,
    SWAP   = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic       prefer2_q, prefer2_d;  // 1: requester 2 wins the next tie
  logic [3:0] reg_a_q, reg_a_d;
  logic [3:0] reg_b_q, reg_b_d;
  logic [7:0] op_count_q, op_count_d;
  logic       swap_go;

`ifdef SWAP_REG_ARBITER_SWAP_EN
  assign swap_go = swap_req;
`else
  logic unused_swap_req;
  assign unused_swap_req = swap_req;
  assign swap_go         = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      prefer2_q  <= 1'b0;
      reg_a_q    <= 4'b0000;
      reg_b_q    <= 4'b0000;
      op_count_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      prefer2_q  <= prefer2_d;
      reg_a_q    <= reg_a_d;
      reg_b_q    <= reg_b_d;
      op_count_q <= op_count_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = IDLE;
    prefer2_d = prefer2_q;
    case (state_q)
      IDLE: begin
        if (req1 && (!req2 || !prefer2_q)) begin
          state_d   = GRANT1;
          prefer2_d = 1'b1;
        end else if (req2) begin
          state_d   = GRANT2;
          prefer2_d = 1'b0;
        end else if (swap_go) begin
          state_d = SWAP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    reg_a_d    = reg_a_q;
    reg_b_d    = reg_b_q;
    op_count_d = op_count_q;
    case (state_q)
      GRANT1: begin
        reg_a_d    = data1;
        reg_b_d    = reg_a_q;
        op_count_d = op_count_q + 8'd1;
      end
      GRANT2: begin
        reg_a_d    = data2;
        reg_b_d    = reg_a_q;
        op_count_d = op_count_q + 8'd1;
      end
      SWAP: begin
        reg_a_d    = reg_b_q;
        reg_b_d    = reg_a_q;
        op_count_d = op_count_q + 8'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    gnt1     = (state_q == GRANT1);
    gnt2     = (state_q == GRANT2);
    busy     = (state_q != IDLE);
    reg_a    = reg_a_q;
    reg_b    = reg_b_q;
    op_count = op_count_q;
  end

endmodule

// File: tb/tb_swap_reg_arbiter.sv
// Scoreboard bench for swap_reg_arbiter: expected register/count results are queued when an
// operation is requested and compared once the DUT completes it.
module tb_swap_reg_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req1 = 1'b0, req2 = 1'b0, swap_req = 1'b0;
  logic [3:0] data1 = 4'h0, data2 = 4'h0;
  logic       gnt1, gnt2, busy;
  logic [3:0] reg_a, reg_b;
  logic [7:0] op_count;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] exp_a = 4'h0, exp_b = 4'h0;
  logic [7:0] exp_cnt = 8'd0;
  int         n_vec = 0;
  int         n_err = 0;

  swap_reg_arbiter dut (
    .clock(clock), .reset(reset),
    .req1(req1), .data1(data1), .req2(req2), .data2(data2), .swap_req(swap_req),
    .gnt1(gnt1), .gnt2(gnt2), .busy(busy),
    .reg_a(reg_a), .reg_b(reg_b), .op_count(op_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_shift(input logic [3:0] d);
    exp_b   = exp_a;
    exp_a   = d;
    exp_cnt = exp_cnt + 8'd1;
    sb.push_back('{a: exp_a, b: exp_b, cnt: exp_cnt});
  endtask

  task automatic push_swap();
    logic [3:0] t;
    t       = exp_a;
    exp_a   = exp_b;
    exp_b   = t;
    exp_cnt = exp_cnt + 8'd1;
    sb.push_back('{a: exp_a, b: exp_b, cnt: exp_cnt});
  endtask

  task automatic compare_regs(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_reg_a"}, 32'(reg_a), 32'(e.a));
      check({tag, "_reg_b"}, 32'(reg_b), 32'(e.b));
      check({tag, "_count"}, 32'(op_count), 32'(e.cnt));
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_a = 4'h0; exp_b = 4'h0; exp_cnt = 8'd0;
    sb.delete();
  endtask

  // Single write from one requester, held until granted (bounded wait).
  task automatic do_write(input int who, input logic [3:0] d, input string tag);
    logic seen;
    seen = 1'b0;
    if (who == 1) begin req1 = 1'b1; data1 = d; end
    else          begin req2 = 1'b1; data2 = d; end
    push_shift(d);
    for (int k = 0; k < 4 && !seen; k++) begin
      step();
      seen = (who == 1) ? gnt1 : gnt2;
    end
    if (!seen) begin
      check({tag, "_grant_timeout"}, 32'd0, 32'd1);
      void'(sb.pop_back());
    end else begin
      check({tag, "_other_gnt"}, 32'((who == 1) ? gnt2 : gnt1), 32'd0);
    end
    req1 = 1'b0; req2 = 1'b0;
    if (seen) begin
      step();
      compare_regs(tag);
    end
  endtask

  initial begin
    // Reset state
    step(); step();
    check("rst_reg_a", 32'(reg_a), 32'h0);
    check("rst_reg_b", 32'(reg_b), 32'h0);
    check("rst_count", 32'(op_count), 32'h0);
    reset = 1'b0;
    step();
    check("post_rst_gnt", 32'({gnt1, gnt2, busy}), 32'h0);

    // Single write A from requester 1
    req1 = 1'b1; data1 = 4'hA;
    push_shift(4'hA);
    step();
    check("w1_gnt1", 32'(gnt1), 32'd1);
    check("w1_gnt2", 32'(gnt2), 32'd0);
    check("w1_busy", 32'(busy), 32'd1);
    req1 = 1'b0;
    step();
    compare_regs("w1");
    check("w1_gnt1_low", 32'(gnt1), 32'd0);

    // Reset coincident with GRANT1 cancels the write
    apply_reset();
    step();
    req1 = 1'b1; data1 = 4'h7;
    step();
    check("rg_gnt1", 32'(gnt1), 32'd1);
    reset = 1'b1; req1 = 1'b0;
    step();
    check("rg_reg_a", 32'(reg_a), 32'h0);
    check("rg_reg_b", 32'(reg_b), 32'h0);
    check("rg_count", 32'(op_count), 32'h0);
    check("rg_idle", 32'({gnt1, gnt2, busy}), 32'h0);
    reset = 1'b0;
    step();
    check("rg_first", 32'({gnt1, gnt2, busy}), 32'h0);

    // Both requesters held from reset: alternating grants 1,2,1,2
    reset = 1'b1;
    req1 = 1'b1; data1 = 4'h3;
    req2 = 1'b1; data2 = 4'h5;
    step();
    reset = 1'b0;
    exp_a = 4'h0; exp_b = 4'h0; exp_cnt = 8'd0;
    sb.delete();
    for (int i = 0; i < 4; i++) push_shift((i % 2 == 0) ? 4'h3 : 4'h5);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("rr%0d_gnt", i), 32'({gnt1, gnt2}), (i % 2 == 0) ? 32'b10 : 32'b01);
      step();
      compare_regs($sformatf("rr%0d", i));
    end
    req1 = 1'b0; req2 = 1'b0;
    step();

    // Load A=A, B=5 for the exchange scenarios
    do_write(2, 4'h5, "ld5");
    do_write(1, 4'hA, "ldA");

`ifdef SWAP_REG_ARBITER_SWAP_EN
    swap_req = 1'b1;
    push_swap();
    step();
    check("sw_busy", 32'(busy), 32'd1);
    check("sw_gnts", 32'({gnt1, gnt2}), 32'd0);
    swap_req = 1'b0;
    step();
    compare_regs("sw");

    // swap_req together with req2: write first, then exchange
    swap_req = 1'b1;
    do_write(2, 4'hC, "sw_w2");
    push_swap();
    step();
    check("sw2_busy", 32'(busy), 32'd1);
    check("sw2_gnts", 32'({gnt1, gnt2}), 32'd0);
    swap_req = 1'b0;
    step();
    compare_regs("sw2");
`else
    swap_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("nosw%0d_busy", i), 32'(busy), 32'd0);
      check($sformatf("nosw%0d_regs", i), 32'({reg_a, reg_b, op_count}),
            32'({exp_a, exp_b, exp_cnt}));
    end
    do_write(2, 4'hC, "nosw_w2");
    step();
    check("nosw_after_busy", 32'(busy), 32'd0);
    swap_req = 1'b0;
`endif

    // 256 single writes wrap op_count back to 0
    apply_reset();
    step();
    for (int i = 0; i < 256; i++) begin
      do_write((i % 2) + 1, 4'(i * 7 + 1), $sformatf("wrap%0d", i));
    end
    check("wrap_count_zero", 32'(op_count), 32'd0);
    check("wrap_sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
